// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file sequencer and its ALU.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_SHL   = 3'b101,
    OP_LOADI = 3'b110,
    OP_NOP   = 3'b111
  } op_t;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer. All results are taken modulo 2^WIDTH.
module seq_alu
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op_t'(op))
      OP_ADD:   y = a + b;
      OP_SUB:   y = a - b;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_SHL:   y = a << b[3:0];
      OP_LOADI: y = imm;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Sequences one three-operand instruction at a time against a 2R/1W register
// file: latch, read operands, execute, write back (4 cycles per instruction).
module regfile_sequencer
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [IDX_W-1:0] instr_rd,
  input  logic [IDX_W-1:0] instr_rs,
  input  logic [IDX_W-1:0] instr_rt,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [IDX_W-1:0] a_index,
  output logic [IDX_W-1:0] b_index,
  input  logic [WIDTH-1:0] a_output,
  input  logic [WIDTH-1:0] b_output,
  output logic [IDX_W-1:0] c_index,
  output logic             we,
  output logic [WIDTH-1:0] d_input,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [IDX_W-1:0] rd_q, rd_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [IDX_W-1:0] a_index_q, a_index_d;
  logic [IDX_W-1:0] b_index_q, b_index_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [IDX_W-1:0] c_index_q, c_index_d;
  logic [WIDTH-1:0] d_input_q, d_input_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] alu_y;

  seq_alu #(.WIDTH(WIDTH)) u_alu (
    .op  (op_q),
    .a   (opa_q),
    .b   (opb_q),
    .imm (imm_q),
    .y   (alu_y)
  );

  // Read indices double as the rs/rt latches: loaded at the handshake so the
  // combinational register-file read is already valid throughout READ.
  // d_input_q is the registered ALU result for the write-back cycle.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    a_index_d = a_index_q;
    b_index_d = b_index_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    c_index_d = c_index_q;
    d_input_d = d_input_q;
    result_d  = result_q;
    zero_d    = zero_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d      = op_t'(instr_op);
          rd_d      = instr_rd;
          imm_d     = instr_imm;
          a_index_d = instr_rs;
          b_index_d = instr_rt;
          state_d   = READ;
        end
      end
      READ: begin
        opa_d   = a_output;
        opb_d   = b_output;
        state_d = EXEC;
      end
      EXEC: begin
        c_index_d = rd_q;
        d_input_d = alu_y;
        state_d   = WRITE;
      end
      WRITE: begin
        if (op_q != OP_NOP) begin
          result_d = d_input_q;
          zero_d   = (d_input_q == '0);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      rd_q      <= '0;
      imm_q     <= '0;
      a_index_q <= '0;
      b_index_q <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      c_index_q <= '0;
      d_input_q <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      a_index_q <= a_index_d;
      b_index_q <= b_index_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      c_index_q <= c_index_d;
      d_input_q <= d_input_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign done        = (state_q == WRITE);
  assign we          = (state_q == WRITE) && (op_q != OP_NOP);
  assign a_index     = a_index_q;
  assign b_index     = b_index_q;
  assign c_index     = c_index_q;
  assign d_input     = d_input_q;
  assign result      = result_q;
  assign zero        = zero_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 8x16 register file.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  instr_op = 3'd0;
  logic [2:0]  instr_rd = 3'd0;
  logic [2:0]  instr_rs = 3'd0;
  logic [2:0]  instr_rt = 3'd0;
  logic [15:0] instr_imm = 16'd0;
  logic [2:0]  a_index, b_index, c_index;
  logic [15:0] a_output, b_output, d_input, result;
  logic        we, done, zero;

  logic [15:0] rf [8];
  int          we_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  regfile_sequencer #(.WIDTH(16), .IDX_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs    (instr_rs),
    .instr_rt    (instr_rt),
    .instr_imm   (instr_imm),
    .a_index     (a_index),
    .b_index     (b_index),
    .a_output    (a_output),
    .b_output    (b_output),
    .c_index     (c_index),
    .we          (we),
    .d_input     (d_input),
    .done        (done),
    .result      (result),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  assign a_output = rf[a_index];
  assign b_output = rf[b_index];

  always @(posedge clk) begin
    if (we) begin
      rf[c_index] <= d_input;
      we_cnt      <= we_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (instr_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (instr_ready !== 1'b1) check({tag, "_ready_timeout"}, 32'(instr_ready), 32'd1);
  endtask

  // Issue one instruction and check every stage; entered just after a negedge.
  task automatic run(input string tag, input logic [2:0] op, input logic [2:0] rd,
                     input logic [2:0] rs, input logic [2:0] rt, input logic [15:0] imm,
                     input logic exp_we, input logic [15:0] exp_d,
                     input logic [15:0] exp_res, input logic exp_zero);
    wait_ready(tag);
    instr_valid = 1'b1;
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check({tag, "_ready_T1"}, 32'(instr_ready), 32'd0);
    check({tag, "_we_T1"}, 32'(we), 32'd0);
    @(negedge clk);
    check({tag, "_done_T2"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, "_done_T3"}, 32'(done), 32'd1);
    check({tag, "_we_T3"}, 32'(we), 32'(exp_we));
    if (exp_we) begin
      check({tag, "_c_index"}, 32'(c_index), 32'(rd));
      check({tag, "_d_input"}, 32'(d_input), 32'(exp_d));
    end
    @(negedge clk);
    check({tag, "_ready_T4"}, 32'(instr_ready), 32'd1);
    check({tag, "_done_T4"}, 32'(done), 32'd0);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
    if (exp_we) check({tag, "_rf_rd"}, 32'(rf[rd]), 32'(exp_d));
  endtask

  initial begin
    int hs;
    int dn;
    int we_snap;
    for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
    #12;
    check("reset_ready", 32'(instr_ready), 32'd1);
    check("reset_we", 32'(we), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_zero", 32'(zero), 32'd1);
    check("reset_d_input", 32'(d_input), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rf[2] <= 16'h0003;
    rf[5] <= 16'h0004;
    rf[6] <= 16'h0001;
    @(negedge clk);

    run("add",   3'b000, 3'd1, 3'd2, 3'd5, 16'h0000, 1'b1, 16'h0007, 16'h0007, 1'b0);
    run("sub",   3'b001, 3'd3, 3'd2, 3'd5, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    run("addwr", 3'b000, 3'd4, 3'd3, 3'd6, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1);
    run("loadi", 3'b110, 3'd7, 3'd1, 3'd2, 16'hBEEF, 1'b1, 16'hBEEF, 16'hBEEF, 1'b0);
    rf[0] <= 16'h0004;
    @(negedge clk);
    run("shl",   3'b101, 3'd6, 3'd7, 3'd0, 16'h0000, 1'b1, 16'hEEF0, 16'hEEF0, 1'b0);
    we_snap = we_cnt;
    run("nop",   3'b111, 3'd5, 3'd1, 3'd2, 16'h0000, 1'b0, 16'h0000, 16'hEEF0, 1'b0);
    check("nop_no_write", 32'(we_cnt), 32'(we_snap));
    check("nop_r5_kept", 32'(rf[5]), 32'h0004);

    // instr_valid held high: exactly one handshake per 4 cycles
    wait_ready("busy");
    instr_valid = 1'b1;
    instr_op = 3'b111; instr_rd = 3'd5; instr_rs = 3'd0; instr_rt = 3'd0;
    hs = 0;
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      if (instr_valid && instr_ready) hs++;
      if (done) dn++;
      @(posedge clk);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("busy_handshakes", 32'(hs), 32'd2);
    check("busy_done_pulses", 32'(dn), 32'd2);
    check("busy_no_write", 32'(we_cnt), 32'(we_snap));
    check("busy_result_kept", 32'(result), 32'hEEF0);

    rf[2] <= 16'h0005;
    @(negedge clk);
    run("rd_eq_rs", 3'b000, 3'd2, 3'd2, 3'd2, 16'h0000, 1'b1, 16'h000A, 16'h000A, 1'b0);

    // reset pulsed during EXEC of an ADD into R1
    wait_ready("rst");
    we_snap = we_cnt;
    instr_valid = 1'b1;
    instr_op = 3'b000; instr_rd = 3'd1; instr_rs = 3'd2; instr_rt = 3'd2;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_we", 32'(we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_c_index", 32'(c_index), 32'd0);
    check("rst_a_index", 32'(a_index), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) @(negedge clk);
    check("rst_no_write", 32'(we_cnt), 32'(we_snap));
    check("rst_r1_kept", 32'(rf[1]), 32'h0007);
    check("rst_ready_after", 32'(instr_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
